// File: rtl/wait_state_ram.sv
// Word-organised RAM with programmable read/write wait states and a ram_ready
// completion pulse. Writes go through byte lanes; reads return the aligned word.
// Optional access counters are built when RAM_ACCESS_CNT_EN is defined.
module wait_state_ram #(
  parameter int unsigned ADDR_BITS  = 12,
  parameter int unsigned READ_WAIT  = 2,
  parameter int unsigned WRITE_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        we,
  input  logic        oe,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_size,
  output logic [31:0] data_out,
  output logic        ram_ready,
  output logic        busy,
  output logic        err
`ifdef RAM_ACCESS_CNT_EN
  ,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
`endif
);

  localparam int unsigned Depth = 1 << ADDR_BITS;
  localparam logic [3:0]  RdWait = 4'(READ_WAIT);
  localparam logic [3:0]  WrWait = 4'(WRITE_WAIT);

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [1:0]  size_q;
  logic        we_q;

  logic [31:0] mem [Depth];

  logic                 req;
  logic [31:0]          eff_addr;
  logic [31:0]          eff_data;
  logic [1:0]           eff_size;
  logic                 eff_we;
  logic                 eff_err;
  logic [ADDR_BITS-1:0] eff_idx;
  logic [3:0]           wait_sel;
  logic                 to_resp;
  logic                 commit_wr;
  logic                 do_rd;
  logic [31:0]          wr_data;
  logic [3:0]           wr_be;
  logic [31:0]          rd_word;

  assign req = (state_q == StIdle) && cs && (we || oe);

  // The live inputs describe the access on the accept edge; latched copies afterwards.
  always_comb begin
    if (state_q == StIdle) begin
      eff_addr = address;
      eff_data = data_in;
      eff_size = data_size;
      eff_we   = we;
    end else begin
      eff_addr = addr_q;
      eff_data = data_q;
      eff_size = size_q;
      eff_we   = we_q;
    end
  end

  assign eff_idx = eff_addr[ADDR_BITS+1:2];

  // Classify the access: reserved size, misalignment or out-of-range address.
  always_comb begin
    eff_err = 1'b0;
    unique case (eff_size)
      SizeByte: eff_err = 1'b0;
      SizeHalf: eff_err = eff_addr[0];
      SizeWord: eff_err = (eff_addr[1:0] != 2'b00);
      default:  eff_err = 1'b1;
    endcase
    if (eff_addr[31:ADDR_BITS+2] != '0) begin
      eff_err = 1'b1;
    end
  end

  assign wait_sel = eff_we ? WrWait : RdWait;

  // Edge that enters RESP: zero-wait or error accept, or the last WAIT cycle.
  always_comb begin
    to_resp = 1'b0;
    if (req) begin
      to_resp = eff_err || (wait_sel == 4'd0);
    end else if (state_q == StWait) begin
      to_resp = (cnt_q == 4'd1);
    end
  end

  assign commit_wr = to_resp && eff_we && !eff_err;
  assign do_rd     = to_resp && !eff_we;

  // Replicate write data across lanes and pick the byte enables from size/offset.
  always_comb begin
    wr_data = eff_data;
    wr_be   = 4'b0000;
    unique case (eff_size)
      SizeByte: begin
        wr_data = {4{eff_data[7:0]}};
        wr_be   = 4'b0001 << eff_addr[1:0];
      end
      SizeHalf: begin
        wr_data = {2{eff_data[15:0]}};
        wr_be   = eff_addr[1] ? 4'b1100 : 4'b0011;
      end
      SizeWord: begin
        wr_data = eff_data;
        wr_be   = 4'b1111;
      end
      default: begin
        wr_data = eff_data;
        wr_be   = 4'b0000;
      end
    endcase
  end

  assign rd_word = mem[eff_idx];

  // Memory array: byte-lane update on the RESP-entry edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (commit_wr && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) begin
          mem[eff_idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // Handshake FSM with registered ram_ready/busy/err and read-data register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      addr_q    <= 32'd0;
      data_q    <= 32'd0;
      size_q    <= 2'b00;
      we_q      <= 1'b0;
      data_out  <= 32'd0;
      ram_ready <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      ram_ready <= 1'b0;
      err       <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req) begin
            addr_q <= address;
            data_q <= data_in;
            size_q <= data_size;
            we_q   <= we;
            busy   <= 1'b1;
            if (to_resp) begin
              state_q   <= StResp;
              cnt_q     <= 4'd0;
              ram_ready <= 1'b1;
              err       <= eff_err;
            end else begin
              state_q <= StWait;
              cnt_q   <= wait_sel;
            end
          end
        end
        StWait: begin
          cnt_q <= cnt_q - 4'd1;
          if (to_resp) begin
            state_q   <= StResp;
            ram_ready <= 1'b1;
            err       <= eff_err;
          end
        end
        StResp: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
      if (do_rd) begin
        data_out <= eff_err ? 32'd0 : rd_word;
      end
    end
  end

`ifdef RAM_ACCESS_CNT_EN
  // Saturating counters of completed, error-free reads and writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count <= 16'd0;
      wr_count <= 16'd0;
    end else if (ram_ready && !err) begin
      if (we_q) begin
        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      end else begin
        if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_wait_state_ram.sv
// Randomised self-checking bench for wait_state_ram against a byte-addressed
// reference model. Counter checks are compiled in with RAM_ACCESS_CNT_EN.
module tb_wait_state_ram;

  localparam int unsigned AB = 12;
  localparam int unsigned RW = 2;
  localparam int unsigned WW = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs, we, oe;
  logic [31:0] address, data_in;
  logic [1:0]  data_size;
  logic [31:0] data_out;
  logic        ram_ready, busy, err;
`ifdef RAM_ACCESS_CNT_EN
  logic [15:0] rd_count, wr_count;
`endif

  wait_state_ram #(
    .ADDR_BITS (AB),
    .READ_WAIT (RW),
    .WRITE_WAIT(WW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cs       (cs),
    .we       (we),
    .oe       (oe),
    .address  (address),
    .data_in  (data_in),
    .data_size(data_size),
    .data_out (data_out),
    .ram_ready(ram_ready),
    .busy     (busy),
    .err      (err)
`ifdef RAM_ACCESS_CNT_EN
    ,
    .rd_count (rd_count),
    .wr_count (wr_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state
  logic [7:0]  ref_mem [int unsigned];
  logic [31:0] exp_dout;
  int          exp_rd, exp_wr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic ref_err(input logic [31:0] a, input logic [1:0] sz);
    logic e;
    e = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
    if (a >= (32'd1 << (AB + 2))) e = 1'b1;
    return e;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] base, w;
    base = a - (a % 4);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = ref_mem[base + i];
    return w;
  endfunction

  // One complete access; leaves the DUT idle and the model updated.
  task automatic access(input logic w, input logic o, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] sz);
    logic e;
    int   lat_exp, n, nb;
    e       = ref_err(a, sz);
    lat_exp = e ? 1 : (w ? int'(WW) + 1 : int'(RW) + 1);
    cs = 1'b1; we = w; oe = o; address = a; data_in = d; data_size = sz;
    @(posedge clk); #1;
    // Scramble inputs to prove the request was latched
    cs = 1'b0; we = 1'b0; oe = 1'b0;
    address = $urandom; data_in = $urandom; data_size = 2'($urandom);
    n = 1;
    while (!ram_ready && n <= 40) begin
      check_eq("busy_wait", 32'(busy), 32'd1);
      check_eq("err_idle", 32'(err), 32'd0);
      @(posedge clk); #1;
      n++;
    end
    check_eq("latency", 32'(n), 32'(lat_exp));
    if (w) begin
      if (!e) begin
        nb = 1 << sz;
        for (int i = 0; i < nb; i++) ref_mem[a + i] = d[8*i +: 8];
        exp_wr++;
      end
    end else begin
      exp_dout = e ? 32'd0 : ref_word(a);
      if (!e) exp_rd++;
    end
    check_eq("err", 32'(err), 32'(e));
    check_eq("busy_resp", 32'(busy), 32'd1);
    check_eq("data_out", data_out, exp_dout);
    @(posedge clk); #1;
    check_eq("ready_pulse", 32'(ram_ready), 32'd0);
    check_eq("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic check_counts();
`ifdef RAM_ACCESS_CNT_EN
    check_eq("rd_count", 32'(rd_count), 32'(exp_rd));
    check_eq("wr_count", 32'(wr_count), 32'(exp_wr));
`endif
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    logic        w;
    int          n;

    cs = 1'b0; we = 1'b0; oe = 1'b0; address = '0; data_in = '0; data_size = '0;
    exp_dout = '0; exp_rd = 0; exp_wr = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_data_out", data_out, 32'd0);
    check_eq("rst_ready", 32'(ram_ready), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_counts();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed sequence
    access(1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 2'd2);
    access(1'b0, 1'b1, 32'h100, 32'h0, 2'd2);
    check_eq("tp_word", data_out, 32'hDEADBEEF);
    access(1'b1, 1'b1, 32'h101, 32'h000000AA, 2'd0);
    access(1'b0, 1'b1, 32'h100, 32'h0, 2'd2);
    check_eq("tp_byte", data_out, 32'hDEADAAEF);
    access(1'b1, 1'b0, 32'h102, 32'h00001234, 2'd1);
    access(1'b1, 1'b0, 32'h103, 32'h0000FFFF, 2'd1);
    access(1'b0, 1'b1, 32'h100, 32'h0, 2'd2);
    check_eq("tp_half", data_out, 32'h1234AAEF);
    access(1'b0, 1'b1, 32'h0001_0000, 32'h0, 2'd2);
    access(1'b0, 1'b1, 32'h104, 32'h0, 2'd3);
    check_counts();

    // Reset during WAIT aborts a pending write
    access(1'b1, 1'b0, 32'h200, 32'hCAFEF00D, 2'd2);
    cs = 1'b1; we = 1'b1; oe = 1'b0; address = 32'h200; data_in = 32'h55555555; data_size = 2'd2;
    @(posedge clk); #1;
    cs = 1'b0; we = 1'b0;
    check_eq("abort_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("abort_data_out", data_out, 32'd0);
    check_eq("abort_busy_rst", 32'(busy), 32'd0);
    n = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (ram_ready) n++;
    end
    check_eq("abort_no_ready", 32'(n), 32'd0);
    exp_dout = '0; exp_rd = 0; exp_wr = 0;
    check_counts();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    access(1'b0, 1'b1, 32'h200, 32'h0, 2'd2);
    check_eq("abort_prior", data_out, 32'hCAFEF00D);

    // Seed a small region so every random read hits defined data
    for (int i = 0; i < 16; i++) access(1'b1, 1'b0, 32'(4 * i), $urandom, 2'd2);

    for (int k = 0; k < 150; k++) begin
      w  = 1'($urandom);
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) a = $urandom | 32'h0000_4000;
      else                          a = 32'($urandom_range(0, 63));
      access(w, w ? 1'($urandom) : 1'b1, a, $urandom, sz);
    end
    check_counts();

    // Continuous cs=oe=1 gives reads every READ_WAIT+2 cycles
    cs = 1'b1; oe = 1'b1; we = 1'b0; address = 32'h100; data_size = 2'd2;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!ram_ready && n < 40);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!ram_ready && n < 40);
    cs = 1'b0; oe = 1'b0;
    check_eq("b2b_period", 32'(n), 32'(RW + 2));
    exp_dout = ref_word(32'h100);
    exp_rd += 2;
    check_eq("b2b_data", data_out, exp_dout);
    @(posedge clk); #1;
    check_eq("b2b_idle", 32'(busy), 32'd0);
    check_counts();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
